dmi_reg_sequencer: RTL
======================

# dmi_reg_sequencer

Core-side DMI request sequencer placed directly downstream of the DMI clock-domain crossing, in the core clock domain. It accepts one `dm::dmi_req_t` at a time from the crossing's core-side valid/ready port and turns it into a single-beat access on the debug module register bus. It then returns a `dm::dmi_resp_t` through a valid/ready response port. Hung register accesses are bounded by a timeout counter, so the response channel can never stall the crossing indefinitely.

## Interface

Parameters:
- `TimeoutCycles`, default 255: maximum number of cycles spent in ACCESS plus WAIT_RD before the access is abandoned. Legal range is 1..65535.

Ports:
- `clk_i`  in  1  core clock. The block has a single clock domain.
- `rst_i`  in  1  reset, synchronous and active-high.
- `dmi_req_i`  in  dm::dmi_req_t  request. Fields: addr[6:0]; op[1:0] (0 NOP, 1 READ, 2 WRITE, 3 reserved); data[31:0].
- `dmi_req_valid_i`  in  1  request valid.
- `dmi_req_ready_o`  out  1  request ready.
- `dmi_resp_o`  out  dm::dmi_resp_t  response. Fields: data[31:0]; resp[1:0] (0 success, 2 failed).
- `dmi_resp_valid_o`  out  1  response valid.
- `dmi_resp_ready_i`  in  1  response ready.
- `reg_req_o`  out  1  register access request.
- `reg_we_o`  out  1  write enable.
- `reg_addr_o`  out  7  register address.
- `reg_wdata_o`  out  32  write data.
- `reg_gnt_i`  in  1  access grant.
- `reg_rvalid_i`  in  1  read data valid.
- `reg_rdata_i`  in  32  read data.
- `reg_err_i`  in  1  access error. Sampled together with `reg_gnt_i` for writes and with `reg_rvalid_i` for reads.
- `timeout_o`  out  1  one-cycle pulse when an access is abandoned.

## Operation

FSM states and transitions:
- **IDLE**
  - `dmi_req_ready_o` is 1 in this state only.
  - On handshake, latch addr, op and data.
  - op 1 or 2 goes to ACCESS.
  - op 0 goes to RESP with {data 0, resp 0}.
  - op 3 goes to RESP with {data 0, resp 2}.
- **ACCESS**
  - Drive `reg_req_o`=1, `reg_we_o`=(op==2), `reg_addr_o` and `reg_wdata_o` from the latched request.
  - Hold them stable until `reg_gnt_i`.
  - On grant of a write, go to RESP with resp = `reg_err_i` ? 2 : 0 and data 0.
  - On grant of a read, go to WAIT_RD.
- **WAIT_RD**
  - `reg_req_o`=0.
  - On `reg_rvalid_i`, go to RESP with data=`reg_rdata_i` and resp = `reg_err_i` ? 2 : 0.
  - When `reg_err_i`=1, data is forced to 0.
- **RESP**
  - `dmi_resp_valid_o`=1 and `dmi_resp_o` is stable until `dmi_resp_ready_i`.
  - On handshake, go to IDLE. The block never accepts a new request in the same cycle as the response handshake.

Timeout counter:
- 16-bit counter, cleared on entry to ACCESS, incremented each cycle in ACCESS or WAIT_RD.
- When it equals `TimeoutCycles` and the completing event (gnt or rvalid) is absent that cycle, the access is abandoned:
  - drop `reg_req_o`;
  - pulse `timeout_o`;
  - go to RESP with {data 0, resp 2}.
- A completing event in the same cycle as the timeout compare wins; no timeout is flagged.

Stray register-bus events:
- `reg_rvalid_i` or `reg_gnt_i` outside the state that expects it is ignored. This includes a late rvalid after a timeout.

Reset (`rst_i`, synchronous):
- State returns to IDLE from any state, including mid-access.
- Counter and latched request are cleared to 0.
- Any in-flight access is dropped without producing a response.

## Timing

Reset values of outputs:
- `dmi_req_ready_o`=1 (IDLE).
- All other outputs 0, including `dmi_resp_o` = {0, 0}.

Latencies, with the request handshake in cycle N:
- NOP or reserved op: `dmi_resp_valid_o` in N+1.
- Write: `reg_req_o` in N+1; with grant in N+1, response valid in N+2.
- Read: grant in N+1 and rvalid in N+2 give response valid in N+3.
  - rvalid is sampled no earlier than the cycle after grant.
  - rvalid in the grant cycle is ignored.
- Each grant wait cycle and each rvalid wait cycle adds one cycle.

Timeout timing:
- The abandon decision is made in cycle N+1+`TimeoutCycles`.
- `timeout_o` pulses in that same cycle.
- Response valid follows in the next cycle.

Throughput: at most one transaction in flight; the minimum request-to-request spacing is 2 cycles for NOP.

## Test plan

- **Reset:** assert `rst_i` for 2 cycles. Required: `dmi_req_ready_o`=1 and every other output 0.
- **NOP then reserved op:** send op=0, then op=3.
  - Required: op=0 gives resp {0, 0} one cycle after accept.
  - Required: op=3 gives resp {0, 2}.
  - Required: `reg_req_o` never asserts.
- **Write:** send addr 0x10, data 0xDEADBEEF, op=2; grant after 3 wait cycles.
  - Required: `reg_req_o`/`reg_we_o`/addr/wdata stable for 4 cycles.
  - Required: resp {0, 0}.
- **Read error path:**
  - Read 0x11 with rdata 0x12345678 -> resp {0x12345678, 0}.
  - Repeat with `reg_err_i`=1 at rvalid -> resp {0, 2}.
- **Timeout:** `TimeoutCycles`=4, read with no grant.
  - Required: `timeout_o` pulses exactly once and resp is {0, 2}.
  - Required: a late rvalid arriving in IDLE is ignored and the next read completes normally.
- **Backpressure and reset mid-access:**
  - Hold `dmi_resp_ready_i`=0 for 5 cycles; required: response stable and `dmi_req_ready_o`=0 throughout.
  - Assert `rst_i` while in WAIT_RD; required: IDLE next cycle and no response emitted.

Source files
------------

// File: rtl/dmi_reg_sequencer.sv
// Core-side DMI request sequencer: turns one DMI request into a single-beat
// debug-module register access and returns a DMI response, bounded by a timeout.

package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_reg_sequencer #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  dm::dmi_req_t dmi_req_i,
  input  logic         dmi_req_valid_i,
  output logic         dmi_req_ready_o,
  output dm::dmi_resp_t dmi_resp_o,
  output logic         dmi_resp_valid_o,
  input  logic         dmi_resp_ready_i,
  output logic         reg_req_o,
  output logic         reg_we_o,
  output logic [6:0]   reg_addr_o,
  output logic [31:0]  reg_wdata_o,
  input  logic         reg_gnt_i,
  input  logic         reg_rvalid_i,
  input  logic [31:0]  reg_rdata_i,
  input  logic         reg_err_i,
  output logic         timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [1:0]  OP_NOP    = 2'd0;
  localparam logic [1:0]  OP_READ   = 2'd1;
  localparam logic [1:0]  OP_WRITE  = 2'd2;
  localparam logic [1:0]  RESP_OK   = 2'd0;
  localparam logic [1:0]  RESP_FAIL = 2'd2;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TimeoutCycles);

  state_e      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [6:0]  addr_reg, addr_next;
  logic [1:0]  op_reg, op_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [1:0]  code_reg, code_next;
  logic        cnt_hit;

  assign cnt_hit = (cnt_reg == TIMEOUT_VAL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      op_reg    <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      code_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      op_reg    <= op_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    addr_next        = addr_reg;
    op_next          = op_reg;
    wdata_next       = wdata_reg;
    rdata_next       = rdata_reg;
    code_next        = code_reg;
    dmi_req_ready_o  = 1'b0;
    dmi_resp_valid_o = 1'b0;
    reg_req_o        = 1'b0;
    reg_we_o         = 1'b0;
    timeout_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        dmi_req_ready_o = 1'b1;
        if (dmi_req_valid_i) begin
          addr_next  = dmi_req_i.addr;
          op_next    = dmi_req_i.op;
          wdata_next = dmi_req_i.data;
          if (dmi_req_i.op == OP_READ || dmi_req_i.op == OP_WRITE) begin
            state_next = ACCESS;
            cnt_next   = '0;
          end else begin
            state_next = RESP;
            rdata_next = '0;
            code_next  = (dmi_req_i.op == OP_NOP) ? RESP_OK : RESP_FAIL;
          end
        end
      end

      ACCESS: begin
        reg_req_o = 1'b1;
        reg_we_o  = (op_reg == OP_WRITE);
        cnt_next  = cnt_reg + 16'd1;
        // A grant in the compare cycle still completes the access.
        if (reg_gnt_i) begin
          if (op_reg == OP_WRITE) begin
            state_next = RESP;
            rdata_next = '0;
            code_next  = reg_err_i ? RESP_FAIL : RESP_OK;
          end else begin
            state_next = WAIT_RD;
          end
        end else if (cnt_hit) begin
          timeout_o  = 1'b1;
          state_next = RESP;
          rdata_next = '0;
          code_next  = RESP_FAIL;
        end
      end

      WAIT_RD: begin
        cnt_next = cnt_reg + 16'd1;
        if (reg_rvalid_i) begin
          state_next = RESP;
          rdata_next = reg_err_i ? 32'd0 : reg_rdata_i;
          code_next  = reg_err_i ? RESP_FAIL : RESP_OK;
        end else if (cnt_hit) begin
          timeout_o  = 1'b1;
          state_next = RESP;
          rdata_next = '0;
          code_next  = RESP_FAIL;
        end
      end

      RESP: begin
        dmi_resp_valid_o = 1'b1;
        if (dmi_resp_ready_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign reg_addr_o  = addr_reg;
  assign reg_wdata_o = wdata_reg;
  assign dmi_resp_o  = {rdata_reg, code_reg};

endmodule
